// File: rtl/sr_pulse_driver.sv
`default_nettype none
// ============================================================================
// Module   : sr_pulse_driver
// Function : Debounces set/reset buttons and issues exclusive, gap-separated
//            active-low S_n / R_n pulses to a master-slave SR flip-flop stage.
// Revision : 1.0 - initial release
// ============================================================================
module sr_pulse_driver #(
    parameter int DB_CYCLES    = 4,
    parameter int CNT_W        = 16,
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_set,
    input  logic btn_reset,
    output logic S_n,
    output logic R_n,
    output logic busy,
    output logic db_set,
    output logic db_reset
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_SET  = 2'd1;
    localparam logic [1:0] c_ST_RST  = 2'd2;
    localparam logic [1:0] c_ST_GAP  = 2'd3;

    localparam int c_PC_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int c_PC_W   = $clog2(c_PC_MAX + 1);

    localparam logic [CNT_W-1:0]  c_DB_LAST    = CNT_W'(DB_CYCLES - 1);
    localparam logic [c_PC_W-1:0] c_PULSE_LAST = c_PC_W'(PULSE_CYCLES - 1);
    localparam logic [c_PC_W-1:0] c_GAP_LAST   = c_PC_W'(GAP_CYCLES - 1);

    // Channel index 0 = set, 1 = reset.
    logic [1:0] w_btn;
    logic [1:0] w_db;
    logic [1:0] w_press;

    assign w_btn = {btn_reset, btn_set};

    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
        logic             r_sync1;
        logic             r_sync2;
        logic             r_db;
        logic             r_db_prev;
        logic [CNT_W-1:0] r_cnt;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_sync1   <= 1'b0;
                r_sync2   <= 1'b0;
                r_db      <= 1'b0;
                r_db_prev <= 1'b0;
                r_cnt     <= '0;
            end else begin
                r_sync1   <= w_btn[gi];
                r_sync2   <= r_sync1;
                r_db_prev <= r_db;
                if (r_sync2 == r_db) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_DB_LAST) begin
                    r_db  <= r_sync2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end

        assign w_db[gi]    = r_db;
        assign w_press[gi] = r_db & ~r_db_prev;
    end

    logic [1:0]        r_state;
    logic [c_PC_W-1:0] r_pcnt;
    logic              r_s_n;
    logic              r_r_n;
    logic [1:0]        r_pend;

    logic [1:0]        w_state_nxt;
    logic [c_PC_W-1:0] w_pcnt_nxt;
    logic              w_s_n_nxt;
    logic              w_r_n_nxt;
    logic [1:0]        w_pend_nxt;
    logic [1:0]        w_req;
    logic              w_decide;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_pcnt  <= '0;
            r_s_n   <= 1'b1;
            r_r_n   <= 1'b1;
            r_pend  <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            r_pcnt  <= w_pcnt_nxt;
            r_s_n   <= w_s_n_nxt;
            r_r_n   <= w_r_n_nxt;
            r_pend  <= w_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pcnt_nxt  = r_pcnt;
        w_s_n_nxt   = 1'b1;
        w_r_n_nxt   = 1'b1;
        w_req       = r_pend | w_press;
        w_pend_nxt  = w_req;
        w_decide    = 1'b0;

        case (r_state)
            c_ST_IDLE: w_decide = 1'b1;
            c_ST_SET: begin
                if (r_pcnt == c_PULSE_LAST) begin
                    w_state_nxt = c_ST_GAP;
                    w_pcnt_nxt  = '0;
                end else begin
                    w_pcnt_nxt = r_pcnt + c_PC_W'(1);
                    w_s_n_nxt  = 1'b0;
                end
            end
            c_ST_RST: begin
                if (r_pcnt == c_PULSE_LAST) begin
                    w_state_nxt = c_ST_GAP;
                    w_pcnt_nxt  = '0;
                end else begin
                    w_pcnt_nxt = r_pcnt + c_PC_W'(1);
                    w_r_n_nxt  = 1'b0;
                end
            end
            c_ST_GAP: begin
                // The last gap cycle doubles as an IDLE decision point.
                if (r_pcnt == c_GAP_LAST) begin
                    w_decide = 1'b1;
                end else begin
                    w_pcnt_nxt = r_pcnt + c_PC_W'(1);
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase

        if (w_decide) begin
            w_state_nxt = c_ST_IDLE;
            w_pcnt_nxt  = '0;
            if (w_req[1]) begin
                w_state_nxt   = c_ST_RST;
                w_r_n_nxt     = 1'b0;
                w_pend_nxt[1] = 1'b0;
            end else if (w_req[0]) begin
                w_state_nxt   = c_ST_SET;
                w_s_n_nxt     = 1'b0;
                w_pend_nxt[0] = 1'b0;
            end
        end
    end

    assign S_n      = r_s_n;
    assign R_n      = r_r_n;
    assign busy     = (r_state != c_ST_IDLE);
    assign db_set   = w_db[0];
    assign db_reset = w_db[1];

endmodule
`default_nettype wire

// File: tb/tb_sr_pulse_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_sr_pulse_driver
// Function : Scoreboard bench for sr_pulse_driver with a window-based
//            debounce model and a request scheduler as reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sr_pulse_driver;

    localparam int c_DB = 4;
    localparam int c_P  = 2;
    localparam int c_G  = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_set = 1'b0;
    logic btn_reset = 1'b0;
    logic S_n, R_n, busy, db_set, db_reset;

    sr_pulse_driver #(
        .DB_CYCLES(c_DB), .CNT_W(16), .PULSE_CYCLES(c_P), .GAP_CYCLES(c_G)
    ) dut (
        .clk(clk), .rst(rst), .btn_set(btn_set), .btn_reset(btn_reset),
        .S_n(S_n), .R_n(R_n), .busy(busy), .db_set(db_set), .db_reset(db_reset)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int start;
        int width;
    } pulse_t;

    pulse_t exp_q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    // Reference model state
    logic [63:0] hsh [2];
    int          hcnt [2];
    logic [1:0]  m_db = '0, m_s1 = '0, m_s2 = '0, m_press = '0, m_pend = '0;
    logic        m_busy = 1'b0;
    int          next_free = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d edge=%0d", nm, act, expv, cyc);
        end
    endtask

    // Debounced level flips once the last DB synchronised samples all disagree
    // with it; requests are served in order with reset first, each pulse
    // blocking new starts for PULSE+GAP edges.
    task automatic model_edge(input logic s, input logic r, input logic rs);
        logic rq_s, rq_r, all_diff;
        logic [1:0] np;
        pulse_t it;
        int last;
        cyc++;
        if (rs) begin
            last = exp_q.size() - 1;
            if (last >= 0 && exp_q[last].start + c_P > cyc)
                exp_q[last].width = cyc - exp_q[last].start;
            for (int i = 0; i < 2; i++) begin
                hsh[i] = '0;
                hcnt[i] = 0;
            end
            m_db = '0; m_s1 = '0; m_s2 = '0; m_press = '0; m_pend = '0;
            m_busy = 1'b0;
            next_free = 0;
        end else begin
            rq_r = m_pend[1] | m_press[1];
            rq_s = m_pend[0] | m_press[0];
            if (cyc >= next_free && (rq_r || rq_s)) begin
                it.ch = rq_r ? 1 : 0;
                it.start = cyc;
                it.width = c_P;
                exp_q.push_back(it);
                next_free = cyc + c_P + c_G;
                m_pend[1] = rq_r && (it.ch != 1);
                m_pend[0] = rq_s && (it.ch != 0);
            end else begin
                m_pend = {rq_r, rq_s};
            end
            m_busy = (cyc < next_free);
            np = '0;
            for (int i = 0; i < 2; i++) begin
                hsh[i] = {hsh[i][62:0], m_s2[i]};
                if (hcnt[i] < 64) hcnt[i]++;
                all_diff = (hcnt[i] >= c_DB);
                for (int j = 0; j < c_DB; j++)
                    if (hsh[i][j] == m_db[i]) all_diff = 1'b0;
                if (all_diff) begin
                    np[i] = ~m_db[i];
                    m_db[i] = ~m_db[i];
                end
            end
            m_press = np;
            m_s2 = m_s1;
            m_s1 = {r, s};
        end
    endtask

    task automatic drive(input logic s, input logic r, input logic rs);
        btn_set = s;
        btn_reset = r;
        rst = rs;
        @(posedge clk);
        model_edge(s, r, rs);
        #1;
    endtask

    task automatic pop_cmp(input int ch, input int st, input int w);
        pulse_t it;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pulse actual=ch%0d@%0d required=none", ch, st);
        end else begin
            it = exp_q.pop_front();
            chk("pulse_ch", ch, it.ch);
            chk("pulse_start", st, it.start);
            chk("pulse_width", w, it.width);
        end
    endtask

    // Monitor: per-cycle flag checks and pulse reconstruction from S_n / R_n.
    initial begin
        logic prev_s, prev_r;
        int st_s, st_r;
        prev_s = 1'b1; prev_r = 1'b1; st_s = 0; st_r = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("flags", {29'd0, busy, db_reset, db_set}, {29'd0, m_busy, m_db[1], m_db[0]});
                chk("exclusive", {31'd0, S_n | R_n}, 32'd1);
                if (prev_s && !S_n) st_s = cyc;
                if (!prev_s && S_n) pop_cmp(0, st_s, cyc - st_s);
                if (prev_r && !R_n) st_r = cyc;
                if (!prev_r && R_n) pop_cmp(1, st_r, cyc - st_r);
                prev_s = S_n;
                prev_r = R_n;
            end
        end
    end

    initial begin
        int t, hs, hr;
        logic vs, vr, rr;
        drive(0, 0, 1);
        mon_en = 1'b1;
        drive(0, 0, 1);
        chk("reset_outs", {27'd0, S_n, R_n, busy, db_set, db_reset}, {27'd0, 5'b11000});

        // Held set press: pulse after edges t+6, t+7.
        t = cyc + 1;
        for (int i = 0; i <= 12; i++) begin
            drive(1, 0, 0);
            chk("s1_S_n", {31'd0, S_n}, {31'd0, !(i == 6 || i == 7)});
            chk("s1_busy", {31'd0, busy}, {31'd0, (i >= 6 && i <= 8)});
            chk("s1_R_n", {31'd0, R_n}, 32'd1);
        end
        for (int i = 0; i < 15; i++) drive(0, 0, 0);

        // Short glitch is filtered.
        for (int i = 0; i < 3; i++) drive(1, 0, 0);
        for (int i = 0; i < 12; i++) begin
            drive(0, 0, 0);
            chk("s2_quiet", {29'd0, db_set, S_n & R_n, busy}, {29'd0, 3'b010});
        end

        // Simultaneous presses: reset first, then set after the gap.
        for (int i = 0; i <= 13; i++) begin
            drive(1, 1, 0);
            chk("s3_R_n", {31'd0, R_n}, {31'd0, !(i == 6 || i == 7)});
            chk("s3_S_n", {31'd0, S_n}, {31'd0, !(i == 9 || i == 10)});
        end
        for (int i = 0; i < 15; i++) drive(0, 0, 0);

        // Reset press lands during the set pulse.
        for (int i = 0; i <= 14; i++) begin
            drive(1, (i >= 1), 0);
            chk("s4_S_n", {31'd0, S_n}, {31'd0, !(i == 6 || i == 7)});
            chk("s4_R_n", {31'd0, R_n}, {31'd0, !(i == 9 || i == 10)});
        end
        for (int i = 0; i < 15; i++) drive(0, 0, 0);

        // rst on the second cycle of R_n with set pending.
        for (int i = 0; i <= 6; i++) drive(1, 1, 0);
        chk("s5_R_n_low", {31'd0, R_n}, 32'd0);
        drive(0, 0, 1);
        chk("s5_after_rst", {29'd0, S_n, R_n, busy}, {29'd0, 3'b110});
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 0);
            chk("s5_no_pulse", {30'd0, S_n, R_n}, {30'd0, 2'b11});
        end

        // Bounce on btn_reset, then steady high.
        drive(0, 1, 0); drive(0, 0, 0); drive(0, 1, 0); drive(0, 1, 0); drive(0, 0, 0);
        for (int i = 0; i <= 12; i++) begin
            drive(0, 1, 0);
            chk("s6_R_n", {31'd0, R_n}, {31'd0, !(i == 6 || i == 7)});
        end
        for (int i = 0; i < 15; i++) drive(0, 0, 0);

        // Randomised segments with bounce and occasional reset.
        hs = 0; hr = 0; vs = 0; vr = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hs == 0) begin vs = 1'($urandom_range(0, 1)); hs = $urandom_range(1, 10); end
            if (hr == 0) begin vr = 1'($urandom_range(0, 1)); hr = $urandom_range(1, 10); end
            hs--; hr--;
            rr = ($urandom_range(0, 199) == 0);
            drive(vs, vr, rr);
        end
        for (int i = 0; i < 40; i++) drive(0, 0, 0);
        chk("drain", exp_q.size(), 0);
        chk("final_idle", {29'd0, S_n, R_n, busy}, {29'd0, 3'b110});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
